dac_wave_sequencer: RTL

DAC_WAVE_SEQUENCER -- requirements
Module: dac_wave_sequencer

---
 rtl/dac_wave_sequencer.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/dac_wave_sequencer.sv
// DAC waveform sequencer: a phase accumulator with a prescaled tick drives
// saw, triangle, square or hold codes, with continuous or burst-count runs.
module dac_wave_sequencer #(
  parameter int ACC_W = 16,
  parameter int DIV_W = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       cfg_we,
  input  logic [1:0] cfg_addr,
  input  logic [7:0] cfg_wdata,
  output logic [7:0] dac_code,
  output logic       dac_update,
  output logic       running,
  output logic       done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [7:0] MID = 8'h80;

  state_t state_q, state_d;

  logic [7:0]       ftw_q, ftw_d;
  logic [1:0]       mode_q, mode_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [7:0]       burst_q, burst_d;
  logic [DIV_W-1:0] rdiv_q, rdiv_d;
  logic [ACC_W-1:0] phase_q, phase_d;
  logic [DIV_W-1:0] pre_q, pre_d;
  logic [7:0]       bcnt_q, bcnt_d;
  logic [7:0]       code_q, code_d;
  logic             upd_q, upd_d;

  logic wr_ftw, wr_ctrl, wr_div, wr_burst;
  logic run_req, stop_req, start;
  logic tick, carry, period, last;
  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] phase_nx;
  logic [7:0]       p_nx;
  logic [7:0]       sample;

  assign wr_ftw   = cfg_we && (cfg_addr == 2'd0);
  assign wr_ctrl  = cfg_we && (cfg_addr == 2'd1);
  assign wr_div   = cfg_we && (cfg_addr == 2'd2);
  assign wr_burst = cfg_we && (cfg_addr == 2'd3);

  assign run_req  = wr_ctrl && cfg_wdata[7];
  assign stop_req = wr_ctrl && !cfg_wdata[7];
  assign start    = enable && run_req && (state_q != S_RUN);

  // Tick and accumulator use the FTW held before any same-cycle write.
  assign tick     = (state_q == S_RUN) && enable && (pre_q == rdiv_q);
  assign sum      = {1'b0, phase_q} + (ACC_W+1)'(ftw_q);
  assign carry    = sum[ACC_W];
  assign phase_nx = sum[ACC_W-1:0];
  assign p_nx     = phase_nx[ACC_W-1 -: 8];
  assign period   = tick && carry;
  assign last     = period && (bcnt_q == 8'd1);

  always_comb begin
    sample = code_q;
    unique case (mode_q)
      2'd0: sample = p_nx;
      2'd1: sample = p_nx[7] ? {~p_nx[6:0], 1'b0}
                             : {p_nx[6:0], 1'b0};
      2'd2: sample = p_nx[7] ? 8'hFF : 8'h00;
      2'd3: sample = code_q;
      default: sample = code_q;
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM: next state; a stop request outranks a final-period carry
  always_comb begin
    state_d = state_q;
    if (enable) begin
      if (stop_req) begin
        state_d = S_IDLE;
      end else begin
        unique case (state_q)
          S_IDLE:  if (run_req) state_d = S_RUN;
          S_RUN:   if (last)    state_d = S_DONE;
          S_DONE:  if (run_req) state_d = S_RUN;
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  // FSM: outputs
  always_comb begin
    running = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      S_RUN:   running = 1'b1;
      S_DONE:  done    = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    ftw_d   = wr_ftw   ? cfg_wdata : ftw_q;
    mode_d  = wr_ctrl  ? cfg_wdata[1:0] : mode_q;
    div_d   = wr_div   ? DIV_W'(cfg_wdata) : div_q;
    burst_d = wr_burst ? cfg_wdata : burst_q;
    rdiv_d  = rdiv_q;
    phase_d = phase_q;
    pre_d   = pre_q;
    bcnt_d  = bcnt_q;
    if (start) begin
      phase_d = '0;
      pre_d   = '0;
      bcnt_d  = burst_q;
      rdiv_d  = div_q;
    end else if (tick) begin
      pre_d   = '0;
      phase_d = phase_nx;
      if (period && (bcnt_q != 8'd0)) bcnt_d = bcnt_q - 8'd1;
    end else if ((state_q == S_RUN) && enable) begin
      pre_d = pre_q + DIV_W'(1);
    end
    if (state_d != S_RUN) pre_d = '0;
  end

  always_comb begin
    code_d = code_q;
    upd_d  = 1'b0;
    if (state_d != S_RUN) begin
      code_d = MID;
    end else if (tick) begin
      code_d = sample;
      upd_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ftw_q   <= '0;
      mode_q  <= '0;
      div_q   <= '0;
      burst_q <= '0;
      rdiv_q  <= '0;
      phase_q <= '0;
      pre_q   <= '0;
      bcnt_q  <= '0;
      code_q  <= MID;
      upd_q   <= 1'b0;
    end else begin
      ftw_q   <= ftw_d;
      mode_q  <= mode_d;
      div_q   <= div_d;
      burst_q <= burst_d;
      rdiv_q  <= rdiv_d;
      phase_q <= phase_d;
      pre_q   <= pre_d;
      bcnt_q  <= bcnt_d;
      code_q  <= code_d;
      upd_q   <= upd_d;
    end
  end

  assign dac_code   = code_q;
  assign dac_update = upd_q;

endmodule
